// File: rtl/lsu_axi_master_pkg.sv
// Shared definitions for the LSU AXI-lite master: reset level, bus widths,
// access-size encodings and the master FSM state encoding.
package lsu_axi_master_pkg;

  localparam logic        RST_ENABLE    = 1'b0;
  localparam int unsigned INST_ADDR_BUS = 32;
  localparam int unsigned MEM_ADDR_BUS  = 32;
  localparam int unsigned MEM_DATA_BUS  = 32;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AR   = 3'd1,
    ST_R    = 3'd2,
    ST_AW   = 3'd3,
    ST_W    = 3'd4,
    ST_B    = 3'd5,
    ST_RESP = 3'd6
  } state_t;

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane alignment for the LSU bus: store data/strobe placement by address
// offset and load data extraction with sign or zero extension. Purely
// combinational. Size 3 (reserved) behaves as a word.
module lsu_lane_align
  import lsu_axi_master_pkg::*;
#(
  parameter int unsigned DATA_W = MEM_DATA_BUS
) (
  input  logic [1:0]        size,
  input  logic              is_unsigned,
  input  logic [1:0]        offset,
  input  logic [DATA_W-1:0] store_data,
  output logic [DATA_W-1:0] store_lane,
  output logic [3:0]        store_strb,
  input  logic [DATA_W-1:0] load_bus,
  output logic [DATA_W-1:0] load_data
);

  logic [4:0]        shamt;
  logic [3:0]        base;
  logic [DATA_W-1:0] load_sh;

  assign shamt = {offset, 3'b000};

  // Lane shift for stores, extract-and-extend for loads; bytes shifted past
  // the top lane are dropped.
  always_comb begin
    base = 4'b1111;
    case (size)
      SIZE_B:  base = 4'b0001;
      SIZE_H:  base = 4'b0011;
      default: base = 4'b1111;
    endcase
    store_lane = store_data << shamt;
    store_strb = base << offset;
    load_sh    = load_bus >> shamt;
    case (size)
      SIZE_B:  load_data = is_unsigned ? {{(DATA_W-8){1'b0}}, load_sh[7:0]}
                                       : {{(DATA_W-8){load_sh[7]}}, load_sh[7:0]};
      SIZE_H:  load_data = is_unsigned ? {{(DATA_W-16){1'b0}}, load_sh[15:0]}
                                       : {{(DATA_W-16){load_sh[15]}}, load_sh[15:0]};
      default: load_data = load_sh;
    endcase
  end

endmodule

// File: rtl/lsu_axi_master.sv
// LSU-side AXI-lite master: one outstanding load (AR/R) or store (AW/W/B),
// result returned through a valid/ready response port.
// Optional macro LSU_MISALIGN_CHK_EN: misaligned half/word requests skip the
// bus and return an error response directly.
module lsu_axi_master
  import lsu_axi_master_pkg::*;
#(
  parameter int unsigned ADDR_W = MEM_ADDR_BUS,
  parameter int unsigned DATA_W = MEM_DATA_BUS,
  parameter int unsigned STRB_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_unsigned_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic [DATA_W-1:0] resp_rdata_o,
  output logic              resp_err_o,
  output logic [ADDR_W-1:0] araddr_o,
  output logic              arvalid_o,
  input  logic              arready_i,
  input  logic [DATA_W-1:0] rdata_i,
  input  logic [31:0]       rresp_i,
  input  logic              rvalid_i,
  output logic              rready_o,
  output logic [ADDR_W-1:0] awaddr_o,
  output logic              awvalid_o,
  input  logic              awready_i,
  output logic [DATA_W-1:0] wdata_o,
  output logic [STRB_W-1:0] wstrb_o,
  output logic              wvalid_o,
  input  logic              wready_i,
  input  logic [31:0]       bresp_i,
  input  logic              bvalid_i,
  output logic              bready_o
);

  state_t            state;
  logic [1:0]        off_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [1:0]        align_size;
  logic [1:0]        align_off;
  logic [DATA_W-1:0] store_lane;
  logic [3:0]        store_strb;
  logic [DATA_W-1:0] load_data;
  logic [ADDR_W-1:0] word_addr;

  assign word_addr = {req_addr_i[ADDR_W-1:2], 2'b00};

  // One aligner serves both directions: stores are placed from the live
  // request while idle, loads are extracted with the latched size/offset.
  assign align_size = (state == ST_IDLE) ? req_size_i      : size_q;
  assign align_off  = (state == ST_IDLE) ? req_addr_i[1:0] : off_q;

  lsu_lane_align #(
    .DATA_W (DATA_W)
  ) u_align (
    .size        (align_size),
    .is_unsigned (uns_q),
    .offset      (align_off),
    .store_data  (req_wdata_i),
    .store_lane  (store_lane),
    .store_strb  (store_strb),
    .load_bus    (rdata_i),
    .load_data   (load_data)
  );

`ifdef LSU_MISALIGN_CHK_EN
  logic misaligned;
  assign misaligned = (req_size_i == SIZE_H) ? req_addr_i[0]
                                             : ((req_size_i != SIZE_B) && (req_addr_i[1:0] != 2'b00));
`endif

  // Channel handshakes and port valid/ready follow the state directly.
  assign req_ready_o  = (state == ST_IDLE);
  assign arvalid_o    = (state == ST_AR);
  assign rready_o     = (state == ST_R);
  assign awvalid_o    = (state == ST_AW);
  assign wvalid_o     = (state == ST_W);
  assign bready_o     = (state == ST_B);
  assign resp_valid_o = (state == ST_RESP);

  // Transaction FSM with registered bus address/data and response payload.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      state        <= ST_IDLE;
      off_q        <= '0;
      size_q       <= '0;
      uns_q        <= 1'b0;
      araddr_o     <= '0;
      awaddr_o     <= '0;
      wdata_o      <= '0;
      wstrb_o      <= '0;
      resp_rdata_o <= '0;
      resp_err_o   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid_i) begin
            off_q  <= req_addr_i[1:0];
            size_q <= req_size_i;
            uns_q  <= req_unsigned_i;
`ifdef LSU_MISALIGN_CHK_EN
            if (misaligned) begin
              resp_rdata_o <= '0;
              resp_err_o   <= 1'b1;
              state        <= ST_RESP;
            end else
`endif
            if (req_we_i) begin
              awaddr_o <= word_addr;
              wdata_o  <= store_lane;
              wstrb_o  <= {{(STRB_W-4){1'b0}}, store_strb};
              state    <= ST_AW;
            end else begin
              araddr_o <= word_addr;
              state    <= ST_AR;
            end
          end
        end
        ST_AR: if (arready_i) state <= ST_R;
        ST_R: begin
          if (rvalid_i) begin
            resp_rdata_o <= load_data;
            resp_err_o   <= (rresp_i != '0);
            state        <= ST_RESP;
          end
        end
        ST_AW: if (awready_i) state <= ST_W;
        ST_W:  if (wready_i) state <= ST_B;
        ST_B: begin
          if (bvalid_i) begin
            resp_rdata_o <= '0;
            resp_err_o   <= (bresp_i != '0);
            state        <= ST_RESP;
          end
        end
        ST_RESP: if (resp_ready_i) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_axi_master.sv
// Self-checking bench for lsu_axi_master: directed cases plus randomized
// loads/stores against a behavioural slave and reference model.
module tb_lsu_axi_master;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_we_i = 1'b0;
  logic [1:0]  req_size_i = '0;
  logic        req_unsigned_i = 1'b0;
  logic [31:0] req_addr_i = '0;
  logic [31:0] req_wdata_i = '0;
  logic        resp_valid_o;
  logic        resp_ready_i = 1'b0;
  logic [31:0] resp_rdata_o;
  logic        resp_err_o;
  logic [31:0] araddr_o;
  logic        arvalid_o;
  logic        arready_i = 1'b0;
  logic [31:0] rdata_i = '0;
  logic [31:0] rresp_i = '0;
  logic        rvalid_i = 1'b0;
  logic        rready_o;
  logic [31:0] awaddr_o;
  logic        awvalid_o;
  logic        awready_i = 1'b0;
  logic [31:0] wdata_o;
  logic [7:0]  wstrb_o;
  logic        wvalid_o;
  logic        wready_i = 1'b0;
  logic [31:0] bresp_i = '0;
  logic        bvalid_i = 1'b0;
  logic        bready_o;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  lsu_axi_master #(
    .ADDR_W (32),
    .DATA_W (32),
    .STRB_W (8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_we_i       (req_we_i),
    .req_size_i     (req_size_i),
    .req_unsigned_i (req_unsigned_i),
    .req_addr_i     (req_addr_i),
    .req_wdata_i    (req_wdata_i),
    .resp_valid_o   (resp_valid_o),
    .resp_ready_i   (resp_ready_i),
    .resp_rdata_o   (resp_rdata_o),
    .resp_err_o     (resp_err_o),
    .araddr_o       (araddr_o),
    .arvalid_o      (arvalid_o),
    .arready_i      (arready_i),
    .rdata_i        (rdata_i),
    .rresp_i        (rresp_i),
    .rvalid_i       (rvalid_i),
    .rready_o       (rready_o),
    .awaddr_o       (awaddr_o),
    .awvalid_o      (awvalid_o),
    .awready_i      (awready_i),
    .wdata_o        (wdata_o),
    .wstrb_o        (wstrb_o),
    .wvalid_o       (wvalid_o),
    .wready_i       (wready_i),
    .bresp_i        (bresp_i),
    .bvalid_i       (bvalid_i),
    .bready_o       (bready_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Load result: pick the addressed bytes, then sign/zero extend numerically.
  function automatic logic [31:0] ref_load(input logic [1:0] size, input logic uns,
                                           input logic [1:0] off, input logic [31:0] bus);
    longint v;
    logic [31:0] sh;
    sh = bus >> (8 * int'(off));
    v  = longint'(sh);
    case (size)
      2'd0: begin v = v % 256;   if (!uns && v >= 128)   v = v - 256;   end
      2'd1: begin v = v % 65536; if (!uns && v >= 32768) v = v - 65536; end
      default: ;
    endcase
    return v[31:0];
  endfunction

  function automatic logic [31:0] ref_strb(input logic [1:0] size, input logic [1:0] off);
    int nb;
    int m;
    nb = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    m  = ((1 << nb) - 1) << int'(off);
    return 32'(m & 15);
  endfunction

  function automatic bit ref_misaligned(input logic [1:0] size, input logic [1:0] off);
`ifdef LSU_MISALIGN_CHK_EN
    if (size == 2'd1) return off[0];
    if (size != 2'd0) return off != 2'd0;
    return 1'b0;
`else
    return 1'b0;
`endif
  endfunction

  task automatic clear_slave();
    arready_i = 1'b0; rvalid_i = 1'b0; awready_i = 1'b0; wready_i = 1'b0; bvalid_i = 1'b0;
  endtask

  // One full transaction: wa/wd/wb are slave stall cycles on the address,
  // data and B channels; hold is how long the response is back-pressured.
  task automatic run_txn(input string name, input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] bus_rd,
                         input logic [31:0] bus_rsp, input int wa, input int wd_lat, input int wb,
                         input int hold);
    int edges, n_addr, ca, cd, cb, exp_edges;
    bit w_early, aw_done, stable, mis;
    logic [31:0] got_araddr, got_awaddr, got_wdata, exp_data, hold_data;
    logic [7:0]  got_wstrb;
    logic        exp_err, hold_err;
    ca = wa; cd = wd_lat; cb = wb;
    n_addr = 0; w_early = 0; aw_done = 0;
    got_araddr = '0; got_awaddr = '0; got_wdata = '0; got_wstrb = '0;
    mis = ref_misaligned(size, addr[1:0]);

    check_eq({name, "_req_ready"}, 32'(req_ready_o), 32'd1);
    req_valid_i = 1'b1; req_we_i = we; req_size_i = size; req_unsigned_i = uns;
    req_addr_i = addr; req_wdata_i = wd;
    @(negedge clk);
    edges = 1;
    req_valid_i = 1'b0; req_we_i = 1'($urandom); req_size_i = 2'($urandom);
    req_unsigned_i = 1'($urandom); req_addr_i = $urandom; req_wdata_i = $urandom;

    while (!resp_valid_o && edges < 200) begin
      clear_slave();
      rdata_i = $urandom; rresp_i = $urandom; bresp_i = $urandom;
      if (wvalid_o) begin
        if (!aw_done) w_early = 1;
        got_wdata = wdata_o; got_wstrb = wstrb_o;
        if (cd == 0) wready_i = 1'b1; else cd--;
      end
      if (awvalid_o) begin
        n_addr++; got_awaddr = awaddr_o;
        if (ca == 0) begin awready_i = 1'b1; aw_done = 1; end else ca--;
      end
      if (arvalid_o) begin
        n_addr++; got_araddr = araddr_o;
        if (ca == 0) arready_i = 1'b1; else ca--;
      end
      if (rready_o) begin
        if (cd == 0) begin rvalid_i = 1'b1; rdata_i = bus_rd; rresp_i = bus_rsp; end else cd--;
      end
      if (bready_o) begin
        if (cb == 0) begin bvalid_i = 1'b1; bresp_i = bus_rsp; end else cb--;
      end
      @(negedge clk);
      edges++;
    end
    clear_slave();

    if (mis) begin
      exp_data = '0; exp_err = 1'b1; exp_edges = 1;
    end else if (we) begin
      exp_data = '0; exp_err = (bus_rsp != 0); exp_edges = 4 + wa + wd_lat + wb;
    end else begin
      exp_data = ref_load(size, uns, addr[1:0], bus_rd); exp_err = (bus_rsp != 0);
      exp_edges = 3 + wa + wd_lat;
    end

    // edges counts clock edges from acceptance to RESP (states visited minus one)
    check_eq({name, "_resp_valid"}, 32'(resp_valid_o), 32'd1);
    check_eq({name, "_latency"}, 32'(edges), 32'(exp_edges));
    check_eq({name, "_rdata"}, resp_rdata_o, exp_data);
    check_eq({name, "_err"}, 32'(resp_err_o), 32'(exp_err));
    check_eq({name, "_req_ready_busy"}, 32'(req_ready_o), 32'd0);
    check_eq({name, "_addr_cycles"}, 32'(n_addr), mis ? 32'd0 : 32'(wa + 1));
    if (!mis && we) begin
      check_eq({name, "_awaddr"}, got_awaddr, addr & 32'hFFFF_FFFC);
      check_eq({name, "_wdata"}, got_wdata, wd << (8 * int'(addr[1:0])));
      check_eq({name, "_wstrb"}, 32'(got_wstrb), ref_strb(size, addr[1:0]));
      check_eq({name, "_w_before_aw"}, 32'(w_early), 32'd0);
    end
    if (!mis && !we) check_eq({name, "_araddr"}, got_araddr, addr & 32'hFFFF_FFFC);

    hold_data = resp_rdata_o; hold_err = resp_err_o; stable = 1;
    repeat (hold) begin
      resp_ready_i = 1'b0;
      @(negedge clk);
      if (!resp_valid_o || resp_rdata_o !== hold_data || resp_err_o !== hold_err || req_ready_o)
        stable = 0;
    end
    check_eq({name, "_resp_stable"}, 32'(stable), 32'd1);
    resp_ready_i = 1'b1;
    @(negedge clk);
    resp_ready_i = 1'b0;
    check_eq({name, "_resp_done"}, 32'(resp_valid_o), 32'd0);
    check_eq({name, "_back_idle"}, 32'(req_ready_o), 32'd1);
  endtask

  initial begin
    int n;
    logic [31:0] rsp;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    check_eq("rst_valids", 32'({arvalid_o, rready_o, awvalid_o, wvalid_o, bready_o, resp_valid_o}), 32'd0);
    check_eq("rst_req_ready", 32'(req_ready_o), 32'd1);
    check_eq("rst_addrs", araddr_o | awaddr_o, 32'd0);
    check_eq("rst_wdata", wdata_o, 32'd0);
    check_eq("rst_wstrb", 32'(wstrb_o), 32'd0);
    check_eq("rst_resp", resp_rdata_o | 32'(resp_err_o), 32'd0);

    run_txn("lw_word",  1'b0, 2'd2, 1'b0, 32'h8000_0004, 32'h0, 32'hDEAD_BEEF, 32'd0, 0, 0, 0, 0);
    check_eq("lw_word_const", resp_rdata_o, 32'hDEAD_BEEF);
    run_txn("lb_signed", 1'b0, 2'd0, 1'b0, 32'h8000_0003, 32'h0, 32'h80FF_0000, 32'd0, 1, 1, 0, 0);
    run_txn("lbu",       1'b0, 2'd0, 1'b1, 32'h8000_0003, 32'h0, 32'h80FF_0000, 32'd0, 0, 2, 0, 1);
    run_txn("sh_half",   1'b1, 2'd1, 1'b0, 32'h8000_0002, 32'h0000_1234, 32'h0, 32'd0, 2, 1, 1, 0);
    run_txn("sw_berr",   1'b1, 2'd2, 1'b0, 32'h8000_0008, 32'hCAFE_F00D, 32'h0, 32'd1, 0, 0, 2, 5);
    run_txn("lw_misal",  1'b0, 2'd2, 1'b0, 32'h8000_0001, 32'h0, 32'h1122_3344, 32'd0, 0, 0, 0, 0);
    run_txn("lh_rerr",   1'b0, 2'd1, 1'b0, 32'h8000_0002, 32'h0, 32'hFFFF_0000, 32'd2, 0, 0, 0, 0);

    // asynchronous reset while waiting in R
    req_valid_i = 1'b1; req_we_i = 1'b0; req_size_i = 2'd2; req_addr_i = 32'h8000_0010;
    @(negedge clk);
    req_valid_i = 1'b0;
    n = 0;
    while (!rready_o && n < 20) begin
      arready_i = arvalid_o;
      @(negedge clk);
      n++;
    end
    arready_i = 1'b0;
    check_eq("mid_rst_in_r", 32'(rready_o), 32'd1);
    rst = 1'b0;
    #1;
    check_eq("mid_rst_valids", 32'({arvalid_o, rready_o, awvalid_o, wvalid_o, bready_o, resp_valid_o}), 32'd0);
    check_eq("mid_rst_idle", 32'(req_ready_o), 32'd1);
    check_eq("mid_rst_resp", resp_rdata_o | 32'(resp_err_o), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_txn("post_rst", 1'b0, 2'd2, 1'b0, 32'h8000_0020, 32'h0, 32'h0BAD_F00D, 32'd0, 1, 0, 0, 0);

    for (int i = 0; i < 150; i++) begin
      rsp = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 3)) : 32'd0;
      run_txn("rnd", 1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom, $urandom, rsp,
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lsu_axi_master.md
Name: lsu_axi_master

Overview:
Initiator end of the core's AXI-lite-style memory bus. It accepts one load or store request at a time from the LSU stage and drives the AR/R or AW/W/B channels to the data SRAM responder. It returns the load data, lane-extracted and sign- or zero-extended, or a store completion with an error flag. It sits between the LSU pipeline stage and the data SRAM.

Parameters:
ADDR_W, 32, request and bus address width
DATA_W, 32, bus data width
STRB_W, 8, bus write-strobe width; only bits [3:0] are ever set

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low (RST_ENABLE = 1'b0)
req_valid_i  in  1  core request valid
req_ready_o  out  1  high only in IDLE
req_we_i  in  1  1 = store, 0 = load
req_size_i  in  2  0 = byte, 1 = half, 2 = word; 3 = reserved, treated as word
req_unsigned_i  in  1  zero-extend the load result
req_addr_i  in  ADDR_W  byte address
req_wdata_i  in  DATA_W  store data, right-aligned
resp_valid_o  out  1  response valid
resp_ready_i  in  1  core accepts the response
resp_rdata_o  out  DATA_W  extended load data; 0 for stores
resp_err_o  out  1  bus error or misalignment
araddr_o  out  ADDR_W / arvalid_o out 1 / arready_i in 1
rdata_i  in  DATA_W / rresp_i in 32 / rvalid_i in 1 / rready_o out 1
awaddr_o  out  ADDR_W / awvalid_o out 1 / awready_i in 1
wdata_o  out  DATA_W / wstrb_o out STRB_W / wvalid_o out 1 / wready_i in 1
bresp_i  in  32 / bvalid_i in 1 / bready_o out 1

Behaviour:
- State register is 3 bits. States: IDLE, AR, R, AW, W, B, RESP. All bus valid/ready outputs are decoded from state only.
- Reset values: state = IDLE. All valid/ready outputs are 0, except req_ready_o = 1 in IDLE. All registered address, data, strobe and response outputs are 0.
- IDLE: on req_valid_i, latch addr, size, unsigned flag, we, shifted wdata and strobe.
  - Load goes to AR. Store goes to AW.
- Bus address is the word-aligned address, req_addr & ~3.
- Lane placement uses addr[1:0]:
  - wdata_o = req_wdata << (8*addr[1:0]).
  - wstrb_o = {4'b0, base << addr[1:0]}, with base = 0001 / 0011 / 1111 for byte / half / word.
- AR: arvalid_o = 1. On arready_i go to R.
- R: rready_o = 1. On rvalid_i:
  - Capture rdata_i >> (8*addr[1:0]), truncated to size, then sign- or zero-extended.
  - err = (rresp_i != 0).
  - Go to RESP.
- AW: awvalid_o = 1. On awready_i go to W. wvalid_o is never asserted before the AW handshake.
- W: wvalid_o = 1. On wready_i go to B.
- B: bready_o = 1. On bvalid_i: err = (bresp_i != 0), rdata = 0, go to RESP.
- RESP: resp_valid_o = 1. Data and err are held stable until resp_ready_i, then go to IDLE. A new request is accepted no earlier than the cycle after the response handshake.
- Each handshake completes in the cycle valid && ready is sampled high.
- The master adds exactly one state cycle per channel. Total latency is therefore the slave latency plus 4 cycles (load) or 5 cycles (store), counting IDLE acceptance through RESP.
- Only one outstanding transaction. There is no AR/AW concurrency, so slave arbitration priority is irrelevant.
- Asynchronous reset asserted mid-transaction: immediately go to IDLE, all valids drop, and the pending response is discarded.
- Illegal state encodings go to IDLE.

Optional Feature:
LSU_MISALIGN_CHK_EN
- Defined: in IDLE, a half request with addr[0] != 0, or a word request with addr[1:0] != 0, generates no bus traffic. The block goes directly to RESP with resp_err_o = 1 and resp_rdata_o = 0.
- Undefined: misaligned requests are issued. Lanes that shift past bit 31 are dropped, and load data is the shifted-in zero-filled value.

Decomposition:
- Shared defines package holds: RST_ENABLE, INST_ADDR_BUS / MEM_ADDR_BUS, MEM_DATA_BUS, size encodings (SIZE_B / SIZE_H / SIZE_W), and the state encodings.
- One sub-module, lsu_lane_align: purely combinational store shift/strobe generation and load extract/extend. It is shared with later cache work.

Test Plan:
- Word load at 0x8000_0004, slave returns 0xDEAD_BEEF with rresp 0:
  - arvalid_o is high with araddr_o = 0x8000_0004.
  - resp_rdata_o = 0xDEAD_BEEF, resp_err_o = 0.
- Signed byte load at 0x8000_0003 with rdata 0x80FF_0000: resp_rdata_o = 0xFFFF_FF80. The same load with req_unsigned_i = 1 gives 0x0000_0080.
- Half store 0x1234 at 0x8000_0002:
  - awaddr_o = 0x8000_0000, wdata_o = 0x1234_0000, wstrb_o = 0x0C.
  - wvalid_o stays low until the AW handshake.
  - With bresp 0, resp_err_o = 0.
- Slave returns bresp_i = 1 on a store: resp_err_o = 1. With resp_ready_i held low for 5 cycles, resp_valid_o and resp_err_o stay stable, and req_ready_o stays 0 until the response is accepted.
- rst driven low while in R: within the same edge all valids = 0 and state = IDLE. The next request after reset completes normally.
- With LSU_MISALIGN_CHK_EN defined, a word load at 0x8000_0001 gives no arvalid_o pulse and RESP two cycles after acceptance with resp_err_o = 1. Without the macro, the same request issues a bus read.
